// File: rtl/score_req_pkg.sv
// Shared definitions for the score-update request driver.
// State encoding, default sizing constants.
package score_req_pkg;

  // Request FSM states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int DEF_PENDING_WIDTH  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 53;
  localparam int DEF_TIMER_WIDTH    = 6;

endpackage

// File: rtl/score_req_timer.sv
// Abort timer for an in-flight score request.
// Cleared while a request is being issued, counts each waiting cycle and
// reports expiry once it reaches TIMEOUT_CYCLES-1 (it then holds there).
module score_req_timer #(
  parameter int TIMER_WIDTH    = 6,
  parameter int TIMEOUT_CYCLES = 53
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic cnt,
  output logic expired
);

  logic [TIMER_WIDTH-1:0] timer;

  assign expired = (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter, saturating at the expiry value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (cnt && !expired) begin
      timer <= timer + TIMER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/score_request_driver.sv
// Initiator side of the score-update enable/ready handshake.
// Hit events are accumulated in a saturating pending counter; one enable
// pulse is issued per event whenever the updater is idle.
// Optional macro SCORE_REQ_TIMEOUT_EN adds an abort timer for stuck requests;
// without it the wait states wait forever and timeout reads 0.
//
// Handshake: ready high means the updater is idle and may take a request.
// enable is a one-cycle pulse, issued only from IDLE while ready is high.
// The updater accepts by dropping ready (WAIT_ACK -> WAIT_DONE) and reports
// completion by raising ready again (WAIT_DONE -> IDLE). ready is not
// looked at while enable is high.
module score_request_driver
  import score_req_pkg::*;
#(
  parameter int PENDING_WIDTH  = DEF_PENDING_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hit,
  input  logic                     clear,
  input  logic                     ready,
  output logic                     enable,
  output logic                     busy,
  output logic [PENDING_WIDTH-1:0] pending,
  output logic                     overflow,
  output logic                     timeout,
  output state_t                   state
);

  logic issue_go;
  logic hit_ok;
  logic pend_full;
  logic abort;

  // A pending event is launched only from IDLE with the updater idle;
  // a flush in the same cycle takes precedence over launching.
  assign issue_go  = (state == S_IDLE) && (pending != '0) && ready && !clear;
  assign hit_ok    = hit && !clear;
  assign pend_full = &pending;

`ifdef SCORE_REQ_TIMEOUT_EN
  logic timer_expired;

  score_req_timer #(
    .TIMER_WIDTH    (TIMER_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (state == S_ISSUE),
    .cnt     ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)),
    .expired (timer_expired)
  );

  // Normal handshake progress wins over expiry in the same cycle
  assign abort = timer_expired &&
                 (((state == S_WAIT_ACK) && ready) ||
                  ((state == S_WAIT_DONE) && !ready));

  // Sticky abort flag, flushed by clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else if (clear) begin
      timeout <= 1'b0;
    end else if (abort) begin
      timeout <= 1'b1;
    end
  end
`else
  logic unused_timer_cfg;

  // Timer sizing is shared with the timeout build but has no logic here
  assign unused_timer_cfg = (TIMEOUT_CYCLES > 0) ^ (TIMER_WIDTH > 0);
  assign abort            = 1'b0;
  assign timeout          = 1'b0;
`endif

  // Request FSM with registered enable and busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      enable <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_go) begin
            state  <= S_ISSUE;
            enable <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state  <= S_WAIT_ACK;
          enable <= 1'b0;
        end
        S_WAIT_ACK: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!ready) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (ready || abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating pending counter and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case ({hit_ok, issue_go})
        2'b10: begin
          if (pend_full) begin
            overflow <= 1'b1;
          end else begin
            pending <= pending + PENDING_WIDTH'(1);
          end
        end
        2'b01:   pending <= pending - PENDING_WIDTH'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_score_request_driver.sv
// Directed bench for score_request_driver: scoreboard of expected enable
// pulses, a small pending-count model and an updater model driving ready.
module tb_score_request_driver;
  import score_req_pkg::*;

  logic       clock;
  logic       reset;
  logic       hit;
  logic       clear;
  logic       ready;
  logic       enable;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;
  logic       timeout;
  state_t     state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_en = -1;
  int pulses  = 0;
  int next_id = 0;
  int model_pending = 0;
  logic [31:0] exp_q[$];

  score_request_driver dut (
    .clock    (clock),
    .reset    (reset),
    .hit      (hit),
    .clear    (clear),
    .ready    (ready),
    .enable   (enable),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .timeout  (timeout),
    .state    (state)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic push_event();
    exp_q.push_back(next_id);
    next_id++;
    model_pending++;
  endtask

  // Wait (bounded) for an enable pulse, then score it
  task automatic wait_enable();
    int  n;
    logic got;
    got = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (enable === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("enable_seen", got, 1'b1);
    if (got) begin
      if (exp_q.size() == 0) begin
        check("unexpected_enable", 32'd1, 32'd0);
      end else begin
        check("enable_order", pulses, exp_q.pop_front());
      end
      pulses++;
      model_pending--;
      check("pending_at_issue", pending, model_pending);
      if (last_en >= 0) check("enable_gap_ge4", (cyc - last_en) >= 4, 1'b1);
      last_en = cyc;
    end
  endtask

  // Updater model: drop ready one cycle after enable, raise it hold_low cycles later
  task automatic serve(input int hold_low);
    wait_enable();
    step();
    check("enable_one_cycle", enable, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < hold_low; i++) begin
      step();
      check("busy_in_wait", busy, 1'b1);
    end
    ready = 1'b1;
    step();
    check("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    logic en_seen;
    reset = 1'b0;
    hit   = 1'b1;
    clear = 1'b0;
    ready = 1'b1;

    // 1. reset held with hit active
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_outputs", {enable, busy, pending, overflow, timeout}, 32'd0);
    end
    check("reset_state", state, S_IDLE);
    hit   = 1'b0;
    reset = 1'b1;
    step();

    // 2. single hit, enable two edges later
    hit = 1'b1;
    push_event();
    step();
    hit = 1'b0;
    check("single_pending_1", pending, 4'd1);
    check("single_no_enable_yet", enable, 1'b0);
    step();
    check("single_enable", enable, 1'b1);
    check("single_busy", busy, 1'b1);
    serve(3);
    check("single_pending_0", pending, 4'd0);

    // 3. three hits while updater busy
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1;
      push_event();
      step();
    end
    hit = 1'b0;
    check("three_pending", pending, 4'd3);
    en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      en_seen = en_seen | enable;
    end
    check("three_no_enable_while_low", en_seen, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) serve(1);
    check("three_drained", pending, 4'd0);

    // 4. saturation and clear
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      hit = 1'b1;
      step();
      if (i == 14) begin
        check("sat_pending_at_15", pending, 4'd15);
        check("sat_no_overflow_yet", overflow, 1'b0);
      end
    end
    check("sat_pending_hold", pending, 4'd15);
    check("sat_overflow", overflow, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    hit   = 1'b0;
    check("clear_pending", pending, 4'd0);
    check("clear_overflow", overflow, 1'b0);
    step();
    check("clear_dropped_hit", pending, 4'd0);
    model_pending = 0;

    // 5. hit coincident with issue
    hit = 1'b1;
    push_event();
    step();
    hit = 1'b0;
    check("coinc_pending_1", pending, 4'd1);
    hit   = 1'b1;
    ready = 1'b1;
    push_event();
    step();
    hit = 1'b0;
    check("coinc_enable", enable, 1'b1);
    check("coinc_pending_held", pending, 4'd1);
    serve(2);
    serve(2);
    check("coinc_drained", pending, 4'd0);

    // Reset during an in-flight request
    hit = 1'b1;
    push_event();
    step();
    hit = 1'b0;
    wait_enable();
    #2 reset = 1'b0;
    #1;
    check("midreset_enable", enable, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_state", state, S_IDLE);
    step();
    reset = 1'b1;
    model_pending = 0;
    step();
    check("midreset_pending", pending, 4'd0);

    // 6. ready stuck high after enable
    hit = 1'b1;
    push_event();
    step();
    hit = 1'b0;
    wait_enable();
`ifdef SCORE_REQ_TIMEOUT_EN
    repeat (53) step();
    check("to_still_waiting", state, S_WAIT_ACK);
    check("to_not_yet", timeout, 1'b0);
    step();
    check("to_flag", timeout, 1'b1);
    check("to_state_idle", state, S_IDLE);
    check("to_busy", busy, 1'b0);
    check("to_pending", pending, 4'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("to_cleared", timeout, 1'b0);
`else
    repeat (60) step();
    check("stuck_busy", busy, 1'b1);
    check("stuck_no_timeout", timeout, 1'b0);
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    step();
    check("stuck_released", busy, 1'b0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
